// File: rtl/codec_i2c_cfg_seq.sv
// WM8731 power-up configuration sequencer.
// Walks an 11-entry register table and writes each entry to the codec over a
// bit-banged I2C bus. Each entry is one write of three bytes: device address,
// {reg, data[8]} and data[7:0]. A NACK on an entry finishes that transaction
// and retries it, up to MAX_RETRY times.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | bus released, waiting for start (or the post-reset auto-start)
// S_START | 2 quarters: SCL=1/SDA released, then SCL=1/SDA low
// S_BIT   | 4 quarters per data bit, SDA valid from q0, SCL high q2..q3
// S_ACK   | 4 quarters, SDA released, slave ACK sampled on the q3 tick
// S_STOP  | 3 quarters: SCL=0/SDA low, SCL=1/SDA low, SCL=1/SDA released
// S_GAP   | 4 quarters of idle bus, then next entry / retry / finish
// S_DONE  | every entry acknowledged
// S_ERR   | retries exhausted on err_index
module codec_i2c_cfg_seq #(
    parameter int unsigned QUARTER_DIV = 125,
    parameter logic [6:0]  DEV_ADDR    = 7'h1A,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       start,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_in,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [3:0] err_index
);

    localparam int DIV_W = (QUARTER_DIV > 1) ? $clog2(QUARTER_DIV) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    // Index is advanced past the last entry on its final ACK; seeing this
    // value at the end of GAP means the whole table has been written.
    localparam logic [3:0] END_INDEX = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         qcnt_q, qcnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         byte_q, byte_d;
    logic [3:0]         index_q, index_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic               nack_q, nack_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [3:0]         err_index_q, err_index_d;
    logic               auto_q;

    logic               tick;
    logic [15:0]        word;
    logic [7:0]         cur_byte;
    logic               tx_bit;

    // Table word = {reg[6:0], data[8:0]}.
    function automatic logic [15:0] table_word(input logic [3:0] idx);
        case (idx)
            4'd0:    table_word = {7'd15, 9'h000};
            4'd1:    table_word = {7'd6,  9'h000};
            4'd2:    table_word = {7'd0,  9'h017};
            4'd3:    table_word = {7'd1,  9'h017};
            4'd4:    table_word = {7'd2,  9'h079};
            4'd5:    table_word = {7'd3,  9'h079};
            4'd6:    table_word = {7'd4,  9'h012};
            4'd7:    table_word = {7'd5,  9'h000};
            4'd8:    table_word = {7'd7,  9'h042};
            4'd9:    table_word = {7'd8,  9'h000};
            4'd10:   table_word = {7'd9,  9'h001};
            default: table_word = 16'h0000;
        endcase
    endfunction

    // Quarter-bit strobe; the divider only runs during a table run.
    assign tick  = busy_q && (div_q == DIV_W'(QUARTER_DIV - 1));
    assign div_d = (busy_q && !tick) ? div_q + DIV_W'(1) : '0;

    // Select the byte being shifted out and the current MSB-first bit.
    always_comb begin
        word = table_word(index_q);
        case (byte_q)
            2'd0:    cur_byte = {DEV_ADDR, 1'b0};
            2'd1:    cur_byte = word[15:8];
            default: cur_byte = word[7:0];
        endcase
        tx_bit = cur_byte[3'd7 - bit_q];
    end

    // State and datapath registers; reset releases the bus at once.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            qcnt_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            index_q     <= '0;
            retry_q     <= '0;
            nack_q      <= 1'b0;
            div_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
            auto_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            nack_q      <= nack_d;
            div_q       <= div_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            auto_q      <= 1'b0;
        end
    end

    // Next-state logic: bus phases advance only on the quarter tick.
    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        index_d     = index_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start || auto_q) begin
                    state_d     = S_START;
                    qcnt_d      = '0;
                    bit_d       = '0;
                    byte_d      = '0;
                    index_d     = '0;
                    retry_d     = '0;
                    nack_d      = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_index_d = '0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (qcnt_q == 2'd1) begin
                        state_d = S_BIT;
                        qcnt_d  = '0;
                        bit_d   = '0;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            S_BIT: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        if (i2c_sdat_in) begin
                            state_d = S_STOP;
                            nack_d  = 1'b1;
                        end else if (byte_q == 2'd2) begin
                            state_d = S_STOP;
                            index_d = index_q + 4'd1;
                            retry_d = '0;
                        end else begin
                            state_d = S_BIT;
                            byte_d  = byte_q + 2'd1;
                            bit_d   = '0;
                        end
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (qcnt_q == 2'd2) begin
                        state_d = S_GAP;
                        qcnt_d  = '0;
                    end else begin
                        qcnt_d = qcnt_q + 2'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    qcnt_d = qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        byte_d = '0;
                        bit_d  = '0;
                        if (nack_q) begin
                            nack_d = 1'b0;
                            if (retry_q == RTY_W'(MAX_RETRY)) begin
                                state_d     = S_ERR;
                                err_d       = 1'b1;
                                err_index_d = index_q;
                                busy_d      = 1'b0;
                            end else begin
                                state_d = S_START;
                                retry_d = retry_q + RTY_W'(1);
                            end
                        end else if (index_q == END_INDEX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            index_d = '0;
                        end else begin
                            state_d = S_START;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive decoded from state and quarter; idle states release the bus.
    always_comb begin
        i2c_sclk    = 1'b1;
        i2c_sdat_oe = 1'b0;
        case (state_q)
            S_START: i2c_sdat_oe = qcnt_q[0];
            S_BIT: begin
                i2c_sclk    = qcnt_q[1];
                i2c_sdat_oe = ~tx_bit;
            end
            S_ACK:   i2c_sclk = qcnt_q[1];
            S_STOP: begin
                i2c_sclk    = (qcnt_q != 2'd0);
                i2c_sdat_oe = (qcnt_q != 2'd2);
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_err   = err_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_codec_i2c_cfg_seq.sv
// Directed bench for codec_i2c_cfg_seq with an I2C slave/bus monitor model.
module tb_codec_i2c_cfg_seq;

    localparam int QD = 2;

    logic       clk;
    logic       reset_reset;
    logic       start;
    logic       i2c_sclk;
    logic       i2c_sdat_oe;
    logic       i2c_sdat_in;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic [3:0] err_index;

    int vectors = 0;
    int miscompares = 0;

    // Expected {reg, data[8]} , data[7:0] per entry, worked out by hand.
    logic [15:0] exp_word [11] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217,
                                   16'h0479, 16'h0679, 16'h0812, 16'h0A00,
                                   16'h0E42, 16'h1000, 16'h1201};

    // Slave / monitor state
    bit        mon_clr = 0;
    int        nack_mode = 0;   // 0 none, 1 NACK entry 4 address once, 2 NACK entry 6 always
    bit        slv_pull = 0;
    bit        prev_scl = 1, prev_sda = 1;
    bit        in_txn = 0, in_ack = 0, nacked = 0, nack_once_done = 0;
    int        bitcnt = 0, bytecnt = 0;
    logic [7:0] shreg = 0, b0 = 0, b1 = 0, b2 = 0;
    int        txn_count = 0, cur_entry = 0, proto_err = 0;
    int        seg_len = 0, min_seg = 1000000;
    int        attempts [11];
    logic [7:0]  rec_b0 [11];
    logic [15:0] rec_word [11];
    wire       sda_line = ~i2c_sdat_oe & ~slv_pull;

    assign i2c_sdat_in = sda_line;

    codec_i2c_cfg_seq #(.QUARTER_DIV(QD)) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .start       (start),
        .i2c_sclk    (i2c_sclk),
        .i2c_sdat_oe (i2c_sdat_oe),
        .i2c_sdat_in (i2c_sdat_in),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err),
        .err_index   (err_index)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        bit scl, sda, nak;
        scl = i2c_sclk;
        sda = sda_line;
        if (reset_reset || mon_clr) begin
            in_txn = 0; in_ack = 0; nacked = 0; nack_once_done = 0;
            bitcnt = 0; bytecnt = 0; txn_count = 0; cur_entry = 0;
            proto_err = 0; seg_len = 0; min_seg = 1000000; slv_pull = 0;
            for (int i = 0; i < 11; i++) begin
                attempts[i] = 0; rec_b0[i] = 0; rec_word[i] = 0;
            end
        end else begin
            if (scl == prev_scl) seg_len++;
            else begin
                if (seg_len < min_seg) min_seg = seg_len;
                seg_len = 1;
            end
            if (prev_scl && scl && prev_sda && !sda) begin
                if (in_txn) proto_err++;
                in_txn = 1; in_ack = 0; bitcnt = 0; bytecnt = 0; nacked = 0;
            end else if (prev_scl && scl && !prev_sda && sda) begin
                if (!in_txn || bitcnt != 1) proto_err++;
                if (in_txn) begin
                    txn_count++;
                    if (cur_entry < 11) attempts[cur_entry]++;
                    if (!nacked && bytecnt == 3) begin
                        if (cur_entry < 11) begin
                            rec_b0[cur_entry] = b0;
                            rec_word[cur_entry] = {b1, b2};
                        end
                        cur_entry++;
                    end
                end
                in_txn = 0;
            end else if (in_txn && !prev_scl && scl) begin
                if (!in_ack) begin
                    shreg = {shreg[6:0], sda};
                    bitcnt++;
                end
            end else if (in_txn && prev_scl && !scl) begin
                if (in_ack) begin
                    in_ack = 0; slv_pull = 0; bitcnt = 0;
                end else if (bitcnt == 8) begin
                    if (bytecnt == 0) b0 = shreg;
                    else if (bytecnt == 1) b1 = shreg;
                    else b2 = shreg;
                    nak = 0;
                    if (bytecnt == 0 && nack_mode == 1 && cur_entry == 4 && !nack_once_done) begin
                        nak = 1; nack_once_done = 1;
                    end
                    if (bytecnt == 0 && nack_mode == 2 && cur_entry == 6) nak = 1;
                    if (nak) nacked = 1;
                    slv_pull = !nak;
                    in_ack = 1;
                    bytecnt++;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    end

    task automatic wait_idle(input int budget, output int n, output bit ok);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < budget);
        ok = !busy;
    endtask

    task automatic pulse_start(input bit clr);
        @(posedge clk); #1;
        start = 1; mon_clr = clr;
        @(posedge clk); #1;
        start = 0; mon_clr = 0;
    endtask

    task automatic test_reset();
        reset_reset = 1; start = 0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (i2c_sclk !== 1'b1) begin $display("FAIL reset_sclk: got %b want 1", i2c_sclk); miscompares++; end
        vectors++; if (i2c_sdat_oe !== 1'b0) begin $display("FAIL reset_oe: got %b want 0", i2c_sdat_oe); miscompares++; end
        vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
        vectors++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); miscompares++; end
        vectors++; if (ack_err !== 1'b0) begin $display("FAIL reset_ack_err: got %b want 0", ack_err); miscompares++; end
        vectors++; if (err_index !== 4'd0) begin $display("FAIL reset_err_index: got %0d want 0", err_index); miscompares++; end
    endtask

    task automatic test_full_run();
        int n; bit ok;
        nack_mode = 0;
        @(posedge clk); #1;
        reset_reset = 0;
        wait_idle(20000, n, ok);
        vectors++; if (!ok) begin $display("FAIL full_timeout: busy still %b after %0d cycles", busy, n); miscompares++; end
        vectors++; if (n < 11*117*QD - 2 || n > 11*117*QD + 2) begin
            $display("FAIL full_done_time: got %0d cycles want %0d +/-2", n, 11*117*QD); miscompares++; end
        vectors++; if (done !== 1'b1) begin $display("FAIL full_done: got %b want 1", done); miscompares++; end
        vectors++; if (ack_err !== 1'b0) begin $display("FAIL full_ack_err: got %b want 0", ack_err); miscompares++; end
        vectors++; if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0) begin
            $display("FAIL full_bus_idle: got sclk=%b oe=%b want 1/0", i2c_sclk, i2c_sdat_oe); miscompares++; end
        vectors++; if (txn_count != 11) begin $display("FAIL full_txn_count: got %0d want 11", txn_count); miscompares++; end
        vectors++; if (rec_b0[8] !== 8'h34) begin $display("FAIL full_e8_b0: got %h want 34", rec_b0[8]); miscompares++; end
        vectors++; if (rec_word[8][15:8] !== 8'h0E) begin $display("FAIL full_e8_b1: got %h want 0e", rec_word[8][15:8]); miscompares++; end
        vectors++; if (rec_word[8][7:0] !== 8'h42) begin $display("FAIL full_e8_b2: got %h want 42", rec_word[8][7:0]); miscompares++; end
        for (int i = 0; i < 11; i++) begin
            vectors++; if (rec_b0[i] !== 8'h34 || rec_word[i] !== exp_word[i]) begin
                $display("FAIL full_entry%0d: got %h/%h want 34/%h", i, rec_b0[i], rec_word[i], exp_word[i]); miscompares++; end
        end
        vectors++; if (proto_err != 0) begin $display("FAIL proto_sda_change: got %0d errors want 0", proto_err); miscompares++; end
        vectors++; if (min_seg < QD) begin $display("FAIL proto_scl_glitch: got min %0d cycles want >= %0d", min_seg, QD); miscompares++; end
    endtask

    task automatic test_nack_once();
        int n; bit ok;
        nack_mode = 1;
        pulse_start(1);
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL nack1_restart: got busy=%b done=%b want 1/0", busy, done); miscompares++; end
        wait_idle(20000, n, ok);
        vectors++; if (!ok) begin $display("FAIL nack1_timeout: busy still %b after %0d cycles", busy, n); miscompares++; end
        vectors++; if (done !== 1'b1 || ack_err !== 1'b0) begin
            $display("FAIL nack1_status: got done=%b ack_err=%b want 1/0", done, ack_err); miscompares++; end
        vectors++; if (txn_count != 12) begin $display("FAIL nack1_txn_count: got %0d want 12", txn_count); miscompares++; end
        vectors++; if (attempts[4] != 2) begin $display("FAIL nack1_e4_attempts: got %0d want 2", attempts[4]); miscompares++; end
        for (int i = 0; i < 11; i++) begin
            vectors++; if (rec_word[i] !== exp_word[i]) begin
                $display("FAIL nack1_entry%0d: got %h want %h", i, rec_word[i], exp_word[i]); miscompares++; end
        end
    endtask

    task automatic test_nack_always();
        int n; bit ok;
        nack_mode = 2;
        pulse_start(1);
        wait_idle(20000, n, ok);
        vectors++; if (!ok) begin $display("FAIL nack6_timeout: busy still %b after %0d cycles", busy, n); miscompares++; end
        vectors++; if (ack_err !== 1'b1) begin $display("FAIL nack6_ack_err: got %b want 1", ack_err); miscompares++; end
        vectors++; if (err_index !== 4'd6) begin $display("FAIL nack6_err_index: got %0d want 6", err_index); miscompares++; end
        vectors++; if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL nack6_status: got done=%b busy=%b want 0/0", done, busy); miscompares++; end
        vectors++; if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0) begin
            $display("FAIL nack6_bus: got sclk=%b oe=%b want 1/0", i2c_sclk, i2c_sdat_oe); miscompares++; end
        vectors++; if (attempts[6] != 4) begin $display("FAIL nack6_attempts: got %0d want 4", attempts[6]); miscompares++; end
        vectors++; if (txn_count != 10) begin $display("FAIL nack6_txn_count: got %0d want 10", txn_count); miscompares++; end
    endtask

    task automatic test_back_to_back();
        int n; bit ok;
        nack_mode = 0;
        pulse_start(1);
        vectors++; if (ack_err !== 1'b0 || err_index !== 4'd0 || busy !== 1'b1) begin
            $display("FAIL b2b_err_clear: got ack_err=%b err_index=%0d busy=%b want 0/0/1", ack_err, err_index, busy); miscompares++; end
        n = 0;
        while (cur_entry < 3 && n < 20000) begin @(posedge clk); #1; n++; end
        vectors++; if (cur_entry != 3 || busy !== 1'b1) begin
            $display("FAIL b2b_reach_e3: got entry %0d busy=%b want 3/1", cur_entry, busy); miscompares++; end
        pulse_start(0);
        wait_idle(20000, n, ok);
        vectors++; if (!ok || done !== 1'b1) begin $display("FAIL b2b_run1_done: got done=%b ok=%b want 1/1", done, ok); miscompares++; end
        vectors++; if (txn_count != 11) begin $display("FAIL b2b_ignored_start: got %0d txns want 11", txn_count); miscompares++; end
        pulse_start(1);
        vectors++; if (done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL b2b_done_clear: got done=%b busy=%b want 0/1", done, busy); miscompares++; end
        wait_idle(20000, n, ok);
        vectors++; if (!ok || done !== 1'b1) begin $display("FAIL b2b_run2_done: got done=%b ok=%b want 1/1", done, ok); miscompares++; end
        vectors++; if (txn_count != 11) begin $display("FAIL b2b_run2_txns: got %0d want 11", txn_count); miscompares++; end
        for (int i = 0; i < 11; i++) begin
            vectors++; if (rec_word[i] !== exp_word[i]) begin
                $display("FAIL b2b_entry%0d: got %h want %h", i, rec_word[i], exp_word[i]); miscompares++; end
        end
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        nack_mode = 0;
        pulse_start(1);
        n = 0;
        while (!(cur_entry == 2 && in_txn && i2c_sclk === 1'b0) && n < 20000) begin
            @(posedge clk); #1; n++;
        end
        vectors++; if (cur_entry != 2 || i2c_sclk !== 1'b0) begin
            $display("FAIL rstmid_reach: got entry %0d sclk=%b want 2/0", cur_entry, i2c_sclk); miscompares++; end
        #2 reset_reset = 1;
        #1;
        vectors++; if (i2c_sclk !== 1'b1 || i2c_sdat_oe !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rstmid_async: got sclk=%b oe=%b busy=%b want 1/0/0", i2c_sclk, i2c_sdat_oe, busy); miscompares++; end
        repeat (2) @(posedge clk);
        #1 reset_reset = 0;
        wait_idle(20000, n, ok);
        vectors++; if (!ok || done !== 1'b1) begin $display("FAIL rstmid_done: got done=%b ok=%b want 1/1", done, ok); miscompares++; end
        vectors++; if (txn_count != 11 || proto_err != 0) begin
            $display("FAIL rstmid_txns: got %0d txns %0d proto errs want 11/0", txn_count, proto_err); miscompares++; end
        for (int i = 0; i < 11; i++) begin
            vectors++; if (rec_word[i] !== exp_word[i]) begin
                $display("FAIL rstmid_entry%0d: got %h want %h", i, rec_word[i], exp_word[i]); miscompares++; end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_nack_once();
        test_nack_always();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
